// File: rtl/stream_pkg.sv
// Shared stream definitions for the dword-to-byte serializer.
package stream_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] stream_byte_t;

  function automatic int idx_width(input int num_bytes);
    return $clog2(num_bytes);
  endfunction

endpackage

// File: rtl/stream_dword_serializer.sv
// Splits valid/ready dword beats into LSB-first bytes, with packet framing
// (partial final word) and wrapping byte/packet counters.
//
// state    | meaning
// EMPTY    | no word held, input may be accepted
// SHIFTING | holding a word, presenting byte idx_q downstream
module stream_dword_serializer
  import stream_pkg::*;
#(
  parameter int NUM_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0]   in_data,
  input  logic                          in_last,
  input  logic [idx_width(NUM_BYTES)-1:0] in_bytes,
  output logic                          out_valid,
  input  logic                          out_ready,
  output stream_byte_t                  out_data,
  output logic                          out_last,
  output logic [CNT_W-1:0]              byte_count,
  output logic [CNT_W-1:0]              pkt_count
);

  localparam int IDX_W  = idx_width(NUM_BYTES);
  localparam int DATA_W = BYTE_W * NUM_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {EMPTY, SHIFTING} state_t;

  state_t            state;
  logic [DATA_W-1:0] word_q;
  logic              hold_last_q;
  logic [IDX_W-1:0]  end_idx_q;
  logic [IDX_W-1:0]  idx_q;

  logic             at_end;
  logic             in_hs;
  logic             out_hs;
  logic [IDX_W-1:0] load_end;

  assign at_end   = (idx_q == end_idx_q);
  assign in_ready = reset_n && ((state == EMPTY) || (out_ready && at_end));
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign load_end = in_last ? in_bytes : LAST_IDX;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= EMPTY;
      word_q      <= '0;
      hold_last_q <= 1'b0;
      end_idx_q   <= '0;
      idx_q       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      byte_count  <= '0;
      pkt_count   <= '0;
    end else begin
      if (out_hs) begin
        byte_count <= byte_count + 1'b1;
        if (out_last) pkt_count <= pkt_count + 1'b1;
      end

      case (state)
        EMPTY: begin
          if (in_hs) begin
            state       <= SHIFTING;
            word_q      <= in_data;
            hold_last_q <= in_last;
            end_idx_q   <= load_end;
            idx_q       <= '0;
            out_valid   <= 1'b1;
            out_data    <= in_data[BYTE_W-1:0];
            out_last    <= in_last && (load_end == '0);
          end
        end
        SHIFTING: begin
          if (out_hs) begin
            if (!at_end) begin
              // word_q[7:0] is the byte on out_data; the next one sits just above it
              idx_q    <= idx_q + 1'b1;
              word_q   <= word_q >> BYTE_W;
              out_data <= word_q[2*BYTE_W-1:BYTE_W];
              out_last <= hold_last_q && ((idx_q + 1'b1) == end_idx_q);
            end else if (in_hs) begin
              word_q      <= in_data;
              hold_last_q <= in_last;
              end_idx_q   <= load_end;
              idx_q       <= '0;
              out_valid   <= 1'b1;
              out_data    <= in_data[BYTE_W-1:0];
              out_last    <= in_last && (load_end == '0);
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_dword_serializer.sv
// Scoreboard bench for stream_dword_serializer: directed plan cases plus random traffic.
module tb_stream_dword_serializer;

  localparam int NB    = 4;
  localparam int CW    = 4;
  localparam int CMASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic [1:0]    in_bytes = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_last;
  logic [CW-1:0] byte_count;
  logic [CW-1:0] pkt_count;

  stream_dword_serializer #(.NUM_BYTES(NB), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .byte_count(byte_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_bytes = 0;
  int   model_pkts = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   rdy_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word contributes (last ? bytes+1 : NB) bytes, LSB first.
  task automatic push_expected(input logic [31:0] data, input logic last, input logic [1:0] bytes);
    int n;
    logic [31:0] d;
    exp_t e;
    d = data;
    n = last ? int'(bytes) + 1 : NB;
    for (int i = 0; i < n; i++) begin
      e.data = d[8*i +: 8];
      e.last = last && (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_word(input logic [31:0] data, input logic last, input logic [1:0] bytes);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_bytes = bytes;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept expected=accept");
    end else begin
      acc_cyc = cyc;
      push_expected(data, last, bytes);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    model_bytes = 0;
    model_pkts  = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_valid actual=0 expected=1");
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // Monitor: every output handshake pops the scoreboard and checks the counters.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      check("byte_count", 32'(byte_count), 32'(model_bytes & CMASK));
      check("pkt_count", 32'(pkt_count), 32'(model_pkts & CMASK));
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_byte actual=%0h expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
        model_bytes++;
        if (e.last) model_pkts++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [7:0] bp_data [6];
    logic       bp_rdy  [6];
    logic       bp_irdy [6];
    logic [7:0] pt_data [6];

    // Reset then idle
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_byte_count", 32'(byte_count), 32'd0);
    check("idle_pkt_count", 32'(pkt_count), 32'd0);

    // Single full packet, latency 1
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork send_word(32'hDDCCBBAA, 1'b1, 2'd3); join_none
    wait_valid();
    check("latency", 32'(cyc - acc_cyc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hDDCCBBAA;
      if (i > 0) @(negedge clk);
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_data", 32'(out_data), 32'(w[8*i +: 8]));
      check("full_last", 32'(out_last), 32'(i == 3));
    end
    wait_drain();
    check("full_byte_count", 32'(byte_count), 32'd4);
    check("full_pkt_count", 32'(pkt_count), 32'd1);
    check("full_idle", 32'(out_valid), 32'd0);

    // Partial last word, back-to-back
    do_reset();
    out_ready = 1'b1;
    pt_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    fork
      begin
        send_word(32'h44332211, 1'b0, 2'd2);
        send_word(32'h00007766, 1'b1, 2'd1);
      end
    join_none
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check("part_valid", 32'(out_valid), 32'd1);
      check("part_data", 32'(out_data), 32'(pt_data[i]));
      check("part_last", 32'(out_last), 32'(i == 5));
    end
    wait_drain();
    check("part_byte_count", 32'(byte_count), 32'd6);
    check("part_pkt_count", 32'(pkt_count), 32'd1);

    // Backpressure: ready 1,0,0,1,...
    do_reset();
    out_ready = 1'b1;
    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_data = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD};
    bp_irdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fork send_word(32'hDDCCBBAA, 1'b1, 2'd3); join_none
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      check("bp_data", 32'(out_data), 32'(bp_data[i]));
      check("bp_in_ready", 32'(in_ready), 32'(bp_irdy[i]));
      check("bp_last", 32'(out_last), 32'(i == 5));
      if (i < 5) begin
        @(posedge clk); #1;
        out_ready = bp_rdy[i+1];
        @(negedge clk);
      end
    end
    wait_drain();
    check("bp_byte_count", 32'(byte_count), 32'd4);

    // Reset mid-word
    do_reset();
    out_ready = 1'b1;
    fork send_word(32'hDDCCBBAA, 1'b1, 2'd3); join_none
    wait_valid();
    check("mid_first", 32'(out_data), 32'hAA);
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    model_bytes = 0;
    model_pkts  = 0;
    @(negedge clk);
    check("mid_in_ready_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_byte_count", 32'(byte_count), 32'd0);
      check("mid_pkt_count", 32'(pkt_count), 32'd0);
    end

    // Counter wrap with 4-bit counters
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_word($urandom, 1'b1, 2'd0);
    wait_drain();
    check("wrap_byte_count", 32'(byte_count), 32'd1);
    check("wrap_pkt_count", 32'(pkt_count), 32'd1);

    // Random traffic with random backpressure
    do_reset();
    rdy_rand = 1;
    for (int i = 0; i < 80; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      send_word($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    wait_drain();
    rdy_rand = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rand_byte_count", 32'(byte_count), 32'(model_bytes & CMASK));
    check("rand_pkt_count", 32'(pkt_count), 32'(model_pkts & CMASK));
    check("rand_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_dword_serializer.md
Name: stream_dword_serializer

Overview:
- Upstream feeder for the sample stream-input interface.
- Accepts 32-bit dword beats on a valid/ready input stream and emits them as 8-bit bytes, least-significant byte first, on a valid/ready output stream.
- The output stream connects directly to the consumer's stream_in_valid / stream_in_ready / stream_in_data.
- Supports packet framing with a partial final word, and keeps byte and packet counters for test observation.

Parameters:
- NUM_BYTES, 4, bytes per input word; input data width is 8*NUM_BYTES. Must be a power of two, at least 2.
- CNT_W, 16, width of the byte_count and pkt_count counters.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  8*NUM_BYTES  input word; byte 0 = bits [7:0].
- in_last  in  1  word is the final word of a packet.
- in_bytes  in  $clog2(NUM_BYTES)  valid bytes minus one; honoured only when in_last=1, otherwise treated as NUM_BYTES-1.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts byte.
- out_data  out  8  output byte.
- out_last  out  1  final byte of a packet.
- byte_count  out  CNT_W  bytes handed off downstream; wraps.
- pkt_count  out  CNT_W  packets completed downstream; wraps.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset values (while reset_n=0):
  - out_valid=0, out_data=0, out_last=0, byte_count=0, pkt_count=0.
  - in_ready=0 (forced low).
  - Internal holding register empty, byte index 0.
- State:
  - One holding register: word, last flag, end index.
  - byte index idx.
  - hold_valid flag.
  - Two states: EMPTY (hold_valid=0) and SHIFTING (hold_valid=1).
- in_ready = reset_n && (!hold_valid || (out_ready && idx==end_idx)). This gives a combinational path from out_ready, which is permitted.
- Accept (in_valid && in_ready):
  - Load word; end_idx = in_last ? in_bytes : NUM_BYTES-1; hold_valid=1; idx=0.
  - First byte appears on out_valid in the following cycle (latency 1).
- Outputs:
  - out_valid = hold_valid.
  - out_data = byte idx of the held word.
  - out_last = hold_last && idx==end_idx.
  - All three are driven from registers.
- Output handshake (out_valid && out_ready):
  - If idx<end_idx: idx++.
  - Otherwise the word is finished: load the next word if accepted in the same cycle (back-to-back, no bubble), else go to EMPTY.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable and no input word is accepted.
- Throughput: one byte per cycle sustained. A full word takes NUM_BYTES cycles, a partial last word takes in_bytes+1 cycles.
- Counters:
  - byte_count += 1 on each output handshake.
  - pkt_count += 1 on each output handshake with out_last=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- in_bytes is ignored when in_last=0, so a non-last word always emits NUM_BYTES bytes.
- Reset mid-word: the held word is discarded, no partial out_last is produced, and counters are cleared.
- Simultaneous completion of the final byte and acceptance of a new word: the new word's byte 0 is presented in the next cycle and idx resets to 0.

Decomposition:
- Package stream_pkg:
  - Constant BYTE_W=8.
  - Typedef stream_byte_t (logic [7:0]).
  - Function for the index width, $clog2(NUM_BYTES).
- No sub-module; the holding register, index, and counters are all small.
- Counters may optionally be a tiny wrap_counter sub-module instantiated twice, since it is reused elsewhere.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n=0 for 3 cycles, then 1, in_valid=0.
  - Response: out_valid=0, in_ready=1, byte_count=0, pkt_count=0.
- Single full packet:
  - Stimulus: in_data=0xDDCCBBAA, in_last=1, in_bytes=3, out_ready=1.
  - Response: out_data AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept; out_last only on DD; byte_count=4, pkt_count=1.
- Partial last word:
  - Stimulus: words 0x44332211 (last=0), then 0x00007766 (last=1, in_bytes=1).
  - Response: 11,22,33,44,66,77 back-to-back with no bubble; out_last on 77; byte_count=6.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 while streaming 0xDDCCBBAA.
  - Response: out_data holds BB through both stall cycles; in_ready stays 0 until DD is handed off.
- Reset mid-word:
  - Stimulus: after AA is handed off, pulse reset_n=0 for 1 cycle.
  - Response: out_valid=0 the next cycle; BB,CC,DD are never emitted; counters are 0.
- Counter wrap (CNT_W=4):
  - Stimulus: send 17 single-byte last words (in_bytes=0).
  - Response: pkt_count=1 and byte_count=1 after the 17th handoff.
